mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter/controller that shares one 4:1 data mux among four requesters.
- Decides ownership from a 4-bit request vector and drives the mux select.
- Registers the selected data word together with a one-hot grant and a valid flag.
- Sits between four producer blocks and a single shared downstream consumer; enforces a bounded hold time so no requester starves.

Parameters:
- WIDTH, 4, data width of each input word and of Y.
- MAX_HOLD, 4, max consecutive cycles one owner keeps the grant while others are requesting; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[k] high = requester k wants the mux.
- i0  input  WIDTH  data from requester 0.
- i1  input  WIDTH  data from requester 1.
- i2  input  WIDTH  data from requester 2.
- i3  input  WIDTH  data from requester 3.
- gnt  output  4  one-hot grant; all zero when idle.
- S  output  2  registered mux select = index of current owner.
- Y  output  WIDTH  registered selected data.
- valid  output  1  high while a grant is active (Y meaningful).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Async reset: gnt=0, S=0, Y=0, valid=0, state=IDLE, hold_cnt=0, last=3, so requester 0 has first priority after reset.
  - Reset mid-grant drops everything immediately (asynchronous); no completion of the current transfer.
- Priority order: search starts at last+1 and wraps modulo 4 (e.g. last=2 -> order 3,0,1,2).
- States: IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; gnt=0, valid=0, Y=0.
  - Else: at the next edge pick winner w by the priority order and go to GRANT.
  - On that edge: gnt=1<<w, S=w, valid=1, Y=i_w, hold_cnt=1.
  - Latency: req high at edge n -> gnt/valid/Y visible after edge n (one cycle).
- GRANT, owner k, evaluated each edge:
  - a) req[k]=0 (release):
    - last=k.
    - If other req bits are set, switch directly to the next winner (no idle bubble), hold_cnt=1.
    - Otherwise go to IDLE: gnt=0, valid=0, Y=0.
  - b) req[k]=1, hold_cnt==MAX_HOLD, and some other req bit set (forced rotation):
    - last=k.
    - Grant the next winner, excluding k, hold_cnt=1.
  - c) req[k]=1 otherwise:
    - Keep the owner; Y=i_k (re-sampled every cycle).
    - hold_cnt increments, saturating at MAX_HOLD.
  - With no competing requesters the owner keeps the grant indefinitely.
- Y is always the data of the owner shown in S/gnt at the same cycle; S, gnt and Y update on the same edge.
- Invariants:
  - gnt is zero or one-hot.
  - valid == |gnt.
  - When valid, S == index of the set gnt bit.
- Simultaneous release and new request: a requester asserting in the same cycle the owner drops is eligible immediately.
- A request dropped before it is granted is simply not granted; nothing is queued.
- Width rules:
  - hold_cnt is 4 bits.
  - Y is a straight copy of the selected input; no arithmetic.

Test Plan:
- Reset: assert rst mid-simulation with req=4'b1111 -> gnt=0, S=0, Y=0, valid=0 immediately; after release, the first grant goes to requester 0.
- Single requester: i0..i3=4,8,1,15, req=4'b0100 held 10 cycles -> one cycle later gnt=4'b0100, S=2, Y=1, valid=1, held for all 10 cycles (no rotation without competition).
- Hold limit: req=4'b1111 constant, MAX_HOLD=4 -> owners 0,1,2,3,0, four cycles each; Y sequence 4,8,1,15,4.
- Early release: owner 1 drops req after 2 cycles with req[3] pending -> next edge gnt=4'b1000, S=3, Y=15; no idle cycle.
- Return to idle: the only owner drops req -> next edge gnt=0, valid=0, Y=0; a later req=4'b0011 grants requester 0 if last=3, else per the rotation order.
- Data tracking: owner 0 held while i0 steps 0..15 -> Y follows i0 with one-cycle latency every cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of a shared 4:1 data mux with bounded hold time
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   req    in   [3:0] request vector, bit k = requester k wants the mux
//   i0..i3 in   [WIDTH-1:0] data words from the four requesters
//   gnt    out  [3:0] registered one-hot grant, zero when idle
//   S      out  [1:0] registered select = index of current owner
//   Y      out  [WIDTH-1:0] registered data of the current owner
//   valid  out  high while a grant is active
module mux4_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       gnt,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Y,
    output logic             valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;

    // Candidates exclude the current owner; in IDLE gnt_q is zero so all
    // requesters compete. The search base is the owner while granting
    // (it becomes "last" on a hand-over) and last_q while idle.
    logic [3:0] others;
    logic [1:0] base;
    logic [1:0] start;
    logic [7:0] doubled;
    logic [7:0] shifted;
    logic [3:0] rot;
    logic [1:0] pos;
    logic [1:0] win;
    logic       any_other;
    logic       at_limit;
    logic       keep;

    assign others    = req & ~gnt_q;
    assign any_other = |others;
    assign base      = (state_q == GRANT) ? s_q : last_q;
    assign start     = base + 2'd1;
    assign doubled   = {others, others};
    // Rotate so that bit 0 of rot is the highest-priority requester.
    assign shifted   = doubled >> start;
    assign rot       = shifted[3:0];

    always_comb begin
        pos = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (rot[j]) begin
                pos = 2'(j);
            end
        end
    end

    assign win      = start + pos;
    assign at_limit = (hold_cnt_q == 4'(MAX_HOLD));
    assign keep     = req[s_q] && !(at_limit && any_other);

    function automatic logic [WIDTH-1:0] pick_data(
        input logic [1:0]       idx,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1,
        input logic [WIDTH-1:0] d2,
        input logic [WIDTH-1:0] d3
    );
        logic [WIDTH-1:0] r;
        case (idx)
            2'd0:    r = d0;
            2'd1:    r = d1;
            2'd2:    r = d2;
            default: r = d3;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        s_d        = s_q;
        y_d        = y_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (any_other) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << win;
                    s_d        = win;
                    y_d        = pick_data(win, i0, i1, i2, i3);
                    valid_d    = 1'b1;
                    hold_cnt_d = 4'd1;
                end else begin
                    gnt_d   = 4'd0;
                    s_d     = 2'd0;
                    y_d     = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                if (keep) begin
                    y_d = pick_data(s_q, i0, i1, i2, i3);
                    if (!at_limit) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end else begin
                    // Release or forced rotation: hand over without a bubble.
                    last_d = s_q;
                    if (any_other) begin
                        gnt_d      = 4'b0001 << win;
                        s_d        = win;
                        y_d        = pick_data(win, i0, i1, i2, i3);
                        valid_d    = 1'b1;
                        hold_cnt_d = 4'd1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = 4'd0;
                        s_d        = 2'd0;
                        y_d        = '0;
                        valid_d    = 1'b0;
                        hold_cnt_d = 4'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            hold_cnt_q <= 4'd0;
            gnt_q      <= 4'd0;
            s_q        <= 2'd0;
            y_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            s_q        <= s_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign S     = s_q;
    assign Y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int W        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] i0, i1, i2, i3;
    logic [3:0]   gnt;
    logic [1:0]   S;
    logic [W-1:0] Y;
    logic         valid;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .gnt   (gnt),
        .S     (S),
        .Y     (Y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   gnt;
        logic [1:0]   s;
        logic [W-1:0] y;
        logic         v;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: m_owner = -1 means idle.
    int m_owner;
    int m_last;
    int m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic int next_winner(input logic [3:0] m, input int from);
        for (int j = 1; j <= 4; j++) begin
            if (m[(from + j) % 4]) return (from + j) % 4;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] data_of(input int k);
        case (k)
            0:       return i0;
            1:       return i1;
            2:       return i2;
            default: return i3;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
    endtask

    // Advance the model for the inputs currently applied and queue the result.
    task automatic model_step();
        exp_t e;
        int   w;
        logic [3:0] rest;
        if (m_owner < 0) begin
            w = next_winner(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
            end
        end else begin
            rest = req & ~(4'b0001 << m_owner);
            if (!req[m_owner] || (m_hold == MAX_HOLD && rest != 4'd0)) begin
                m_last = m_owner;
                w = next_winner(rest, m_owner);
                m_owner = w;
                m_hold  = (w >= 0) ? 1 : 0;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
        if (m_owner < 0) begin
            e.gnt = 4'd0; e.s = 2'd0; e.y = '0; e.v = 1'b0;
        end else begin
            e.gnt = 4'b0001 << m_owner;
            e.s   = 2'(m_owner);
            e.y   = data_of(m_owner);
            e.v   = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_gnt"},   32'(gnt),   32'(e.gnt));
        check({tag, "_valid"}, 32'(valid), 32'(e.v));
        check({tag, "_Y"},     32'(Y),     32'(e.y));
        if (e.v) check({tag, "_S"}, 32'(S), 32'(e.s));
    endtask

    // Drive inputs just after an edge, predict, then check just after the next edge.
    task automatic step(input string tag, input logic [3:0] r);
        req = r;
        model_step();
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic set_data(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
        i0 = a; i1 = b; i2 = c; i3 = d;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'd0;
        set_data(4, 8, 1, 15);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt",   32'(gnt),   32'd0);
        check("reset_S",     32'(S),     32'd0);
        check("reset_Y",     32'(Y),     32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        rst = 1'b0;

        // Idle with no requests.
        step("idle", 4'b0000);

        // Single requester keeps the grant with no competition.
        for (int n = 0; n < 10; n++) step("single", 4'b0100);
        check("single_Y_direct", 32'(Y), 32'd1);

        // Sole owner drops: back to idle.
        step("to_idle", 4'b0000);

        // Reset mid-grant with everyone requesting.
        for (int n = 0; n < 3; n++) step("pre_reset", 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_gnt",   32'(gnt),   32'd0);
        check("async_rst_S",     32'(S),     32'd0);
        check("async_rst_Y",     32'(Y),     32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Hold limit rotation: owners 0,1,2,3,0 for four cycles each.
        for (int n = 0; n < 20; n++) begin
            step("rotate", 4'b1111);
            if (n == 0) check("first_after_reset_gnt", 32'(gnt), 32'b0001);
        end
        check("rotate_end_Y", 32'(Y), 32'd4);

        // Early release from owner 1 with requester 3 pending.
        step("early_a", 4'b1010);
        step("early_b", 4'b1010);
        step("early_c", 4'b1000);
        check("early_gnt_direct", 32'(gnt), 32'b1000);
        check("early_Y_direct",   32'(Y),   32'd15);

        // Return to idle, then 0 and 1 request together (last=3 -> 0 wins).
        step("idle2", 4'b0000);
        step("after_idle", 4'b0011);
        check("after_idle_gnt_direct", 32'(gnt), 32'b0001);

        // Data tracking: Y follows i0 every cycle while owner 0 holds.
        for (int n = 0; n < 16; n++) begin
            i0 = 4'(n);
            step("track", 4'b0001);
        end

        // Simultaneous release and fresh request.
        step("swap", 4'b0100);
        step("swap2", 4'b0100);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            set_data(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            step("random", 4'($urandom_range(0, 15)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
